// File: rtl/cu_pkg.sv
// Shared constants and types for the microc control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cu_pkg;

    // Opcodes of the jump family and the 4-bit prefix shared by li.
    localparam logic [5:0] OP_J      = 6'b000100;
    localparam logic [5:0] OP_JZ     = 6'b001000;
    localparam logic [5:0] OP_JNZ    = 6'b001010;
    localparam logic [3:0] OP_LI_PFX = 4'b0000;

    // ALU operations carried in Opcode[4:2].
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;

    // Run-control FSM state.
    typedef logic [1:0] cu_state_t;
    localparam cu_state_t ST_IDLE = 2'd0;
    localparam cu_state_t ST_RUN  = 2'd1;
    localparam cu_state_t ST_STEP = 2'd2;
    localparam cu_state_t ST_HALT = 2'd3;

    // Raw decoded control fields, before run gating.
    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
    } ctl_t;

endpackage

// File: rtl/cu_microc_if.sv
// Bundle between control unit and datapath/run controller.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level or single-cycle pulses.
interface cu_microc_if #(parameter int CNT_W = 16);
    logic [5:0]       Opcode;
    logic             z;
    logic             start;
    logic             step;
    logic             halt_req;
    logic             s_inc;
    logic             s_inm;
    logic             we3;
    logic             wez;
    logic [2:0]       Op;
    logic             pc_en;
    logic             running;
    logic             trap;
    logic [CNT_W-1:0] retired;

    // Control unit side.
    modport master (
        input  Opcode, z, start, step, halt_req,
        output s_inc, s_inm, we3, wez, Op, pc_en, running, trap, retired
    );

    // Datapath / run controller side.
    modport slave (
        output Opcode, z, start, step, halt_req,
        input  s_inc, s_inm, we3, wez, Op, pc_en, running, trap, retired
    );
endinterface

// File: rtl/cu_decode.sv
// Maps opcode and z flag to raw control fields plus an illegal flag.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module cu_decode
    import cu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output ctl_t       ctl,
    output logic       illegal
);

    // Instruction classes are disjoint; anything unmatched is illegal and
    // leaves the NOP-shaped defaults in place.
    always_comb begin
        ctl     = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0, op: 3'b000};
        illegal = 1'b0;
        if (opcode[5]) begin
            ctl.op  = opcode[4:2];
            ctl.we3 = 1'b1;
            ctl.wez = 1'b1;
        end else if (opcode[5:2] == OP_LI_PFX) begin
            ctl.s_inm = 1'b1;
            ctl.we3   = 1'b1;
        end else if (opcode == OP_J) begin
            ctl.s_inc = 1'b0;
        end else if (opcode == OP_JZ) begin
            ctl.s_inc = ~z;
        end else if (opcode == OP_JNZ) begin
            ctl.s_inc = z;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/cu_microc.sv
// Run-controlled control unit: decode gating, start/step/halt FSM, retire counter.
// Latency: controls 0 cycles from Opcode/z; start/step/halt take effect next cycle.
// Backpressure: none; halt_req stops issue after the current instruction.
// Optional feature: define CU_TRAP_EN to trap illegal opcodes into HALT.
module cu_microc
    import cu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    cu_microc_if.master bus
);

    ctl_t             ctl;
    logic             illegal;
    cu_state_t        state;
    cu_state_t        state_nxt;
    logic [CNT_W-1:0] retired;
    logic             gate_open;
    logic             trap_hit;
    logic             exec;
    logic             trap_clr;

    cu_decode u_decode (
        .opcode  (bus.Opcode),
        .z       (bus.z),
        .ctl     (ctl),
        .illegal (illegal)
    );

    assign gate_open = (state == ST_RUN) || (state == ST_STEP);

`ifdef CU_TRAP_EN
    assign trap_hit = gate_open & illegal;
`else
    // Illegal opcodes fall through the decoder as NOPs.
    logic unused_illegal;
    assign unused_illegal = illegal;
    assign trap_hit       = 1'b0;
`endif

    // A trapping instruction is squashed in its own cycle.
    assign exec = gate_open & ~trap_hit;

    assign bus.pc_en   = exec;
    assign bus.we3     = exec & ctl.we3;
    assign bus.wez     = exec & ctl.wez;
    assign bus.s_inc   = exec ? ctl.s_inc : 1'b1;
    assign bus.s_inm   = exec & ctl.s_inm;
    assign bus.Op      = exec ? ctl.op : 3'b000;
    assign bus.running = gate_open;
    assign bus.retired = retired;

    // Leaving HALT by start or step (halt_req not winning) clears the trap.
    assign trap_clr = (state == ST_HALT) & ~bus.halt_req & (bus.start | bus.step);

    // Next state with halt_req > start > step; a trap overrides everything.
    always_comb begin
        state_nxt = state;
        if (trap_hit) begin
            state_nxt = ST_HALT;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (bus.halt_req)   state_nxt = ST_HALT;
                    else if (bus.start) state_nxt = ST_RUN;
                    else if (bus.step)  state_nxt = ST_STEP;
                end
                ST_RUN:  if (bus.halt_req) state_nxt = ST_HALT;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    retired <= '0;
        else if (exec) retired <= retired + 1'b1;
    end

`ifdef CU_TRAP_EN
    logic trap_q;
    // Sticky trap flag, set on a squashed illegal opcode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        trap_q <= 1'b0;
        else if (trap_hit) trap_q <= 1'b1;
        else if (trap_clr) trap_q <= 1'b0;
    end
    assign bus.trap = trap_q;
`else
    logic unused_trap_clr;
    assign unused_trap_clr = trap_clr;
    assign bus.trap        = 1'b0;
`endif

endmodule

// File: tb/tb_cu_microc.sv
// Self-checking bench for cu_microc against a behavioural run/decode model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cu_microc;
    import cu_pkg::*;

    localparam int CNT_W = 16;
`ifdef CU_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cu_microc_if #(.CNT_W(CNT_W)) bus ();
    cu_microc #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;

    typedef enum {M_IDLE, M_RUN, M_STEP, M_HALT} mode_e;
    mode_e m;
    int    m_ret;
    bit    m_trap;

    function automatic bit is_legal(logic [5:0] op);
        return op[5] || (op[5:2] == 4'b0000) || (op == 6'd4) || (op == 6'd8) || (op == 6'd10);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic cyc(string tag, logic [5:0] op, logic zz, logic st, logic sp, logic hr,
                       bit do_chk = 1'b1);
        bit         open;
        bit         ill;
        bit         exec;
        logic       e_we3, e_wez, e_inc, e_inm;
        logic [2:0] e_op;
        bus.Opcode   = op;
        bus.z        = zz;
        bus.start    = st;
        bus.step     = sp;
        bus.halt_req = hr;
        #3;
        open  = (m == M_RUN) || (m == M_STEP);
        ill   = !is_legal(op);
        exec  = open && !(TRAP && ill);
        e_we3 = 0; e_wez = 0; e_inc = 1; e_inm = 0; e_op = 3'b000;
        if (exec) begin
            if (op[5]) begin
                e_we3 = 1; e_wez = 1; e_op = op[4:2];
            end else if (op[5:2] == 4'b0000) begin
                e_we3 = 1; e_inm = 1;
            end else if (op == 6'd4)  e_inc = 0;
            else if (op == 6'd8)      e_inc = !zz;
            else if (op == 6'd10)     e_inc = zz;
        end
        if (do_chk) begin
            chk({tag, ".pc_en"},   bus.pc_en,   exec);
            chk({tag, ".we3"},     bus.we3,     e_we3);
            chk({tag, ".wez"},     bus.wez,     e_wez);
            chk({tag, ".s_inc"},   bus.s_inc,   e_inc);
            chk({tag, ".s_inm"},   bus.s_inm,   e_inm);
            chk({tag, ".Op"},      bus.Op,      e_op);
            chk({tag, ".running"}, bus.running, open);
            chk({tag, ".trap"},    bus.trap,    m_trap);
            chk({tag, ".retired"}, bus.retired, m_ret);
        end
        if (open && TRAP && ill) begin
            m = M_HALT; m_trap = 1;
        end else begin
            case (m)
                M_IDLE, M_HALT: begin
                    if (hr) m = M_HALT;
                    else if (st) begin m = M_RUN;  m_trap = 0; end
                    else if (sp) begin m = M_STEP; m_trap = 0; end
                end
                M_RUN:  if (hr) m = M_HALT;
                default: m = M_IDLE;
            endcase
        end
        if (exec) m_ret = (m_ret + 1) % 65536;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] rop;
        bus.Opcode = 6'b0; bus.z = 0; bus.start = 0; bus.step = 0; bus.halt_req = 0;
        m = M_IDLE; m_ret = 0; m_trap = 0;
        @(posedge clk);
        #1;
        // Reset values.
        chk("rst.pc_en",   bus.pc_en,   0);
        chk("rst.we3",     bus.we3,     0);
        chk("rst.wez",     bus.wez,     0);
        chk("rst.s_inc",   bus.s_inc,   1);
        chk("rst.s_inm",   bus.s_inm,   0);
        chk("rst.Op",      bus.Op,      0);
        chk("rst.running", bus.running, 0);
        chk("rst.trap",    bus.trap,    0);
        chk("rst.retired", bus.retired, 0);
        reset = 1;

        // Gate closed in IDLE, start opens it next cycle.
        cyc("idle_li", 6'b000010, 0, 0, 0, 0);
        cyc("start",   6'b000010, 0, 1, 0, 0);
        cyc("run_li",  6'b000010, 0, 0, 0, 0);
        chk("li.retired", bus.retired, 1);

        // Decode patterns.
        cyc("alu_add", 6'b101000, 0, 0, 0, 0);
        cyc("alu_sub", 6'b101100, 1, 0, 0, 0);
        cyc("jnz_z0",  6'b001010, 0, 0, 0, 0);
        cyc("jnz_z1",  6'b001010, 1, 0, 0, 0);
        cyc("jz_z1",   6'b001000, 1, 0, 0, 0);
        cyc("jz_z0",   6'b001000, 0, 0, 0, 0);
        cyc("j",       6'b000100, 0, 0, 0, 0);
        cyc("run_ign", 6'b000011, 0, 1, 1, 0);

        // halt_req in cycle K: K executes, K+1 closed.
        cyc("halt_k",  6'b000001, 0, 0, 0, 1);
        cyc("halt_k1", 6'b000001, 0, 0, 0, 0);
        chk("halt.state", dut.state, ST_HALT);
        cyc("resume",  6'b000001, 0, 1, 0, 0);
        cyc("resumed", 6'b110000, 0, 0, 0, 0);

        // Halt, then single step twice through IDLE.
        cyc("halt2",    6'b000001, 0, 0, 0, 1);
        cyc("h_step",   6'b000001, 0, 0, 1, 0);
        cyc("step1",    6'b000010, 0, 0, 0, 0);
        cyc("step1_dn", 6'b000010, 0, 0, 0, 0);
        chk("step1.state", dut.state, ST_IDLE);
        cyc("i_step",   6'b000010, 0, 0, 1, 0);
        cyc("step2",    6'b100100, 0, 0, 0, 0);
        cyc("step2_dn", 6'b100100, 0, 0, 0, 0);

        // Illegal opcode in RUN.
        cyc("ill_start", 6'b000010, 0, 1, 0, 0);
        cyc("illegal",   6'b001111, 0, 0, 0, 0);
        cyc("ill_after", 6'b000010, 0, 0, 0, 0);
        cyc("ill_rst",   6'b000010, 0, 1, 0, 0);
        cyc("ill_run",   6'b000010, 0, 0, 0, 0);

        // Randomized mix of opcodes and run controls.
        for (int i = 0; i < 400; i++) begin
            rop = 6'($urandom);
            cyc("rand", rop, 1'($urandom), ($urandom % 8) == 0, ($urandom % 8) == 0,
                ($urandom % 16) == 0);
        end

        // Asynchronous reset in the middle of RUN.
        cyc("rr_a", 6'b000010, 0, 1, 0, 0);
        cyc("rr_b", 6'b000010, 0, 1, 0, 0);
        cyc("rr_c", 6'b000010, 0, 0, 0, 0);
        bus.Opcode = 6'b100000;
        #3;
        reset = 0;
        #1;
        chk("arst.pc_en",   bus.pc_en,   0);
        chk("arst.we3",     bus.we3,     0);
        chk("arst.wez",     bus.wez,     0);
        chk("arst.running", bus.running, 0);
        chk("arst.retired", bus.retired, 0);
        m = M_IDLE; m_ret = 0; m_trap = 0;
        @(posedge clk);
        #1;
        reset = 1;

        // Counter wrap at all-ones.
        cyc("wrap_start", 6'b000010, 0, 1, 0, 0);
        while (m_ret != 65535) begin
            rop = 6'($urandom_range(32, 63));
            cyc("wrap", rop, 1'($urandom), 0, 0, 0, 1'b0);
        end
        cyc("wrap_ffff", 6'b000000, 0, 0, 0, 0);
        chk("wrap.zero", bus.retired, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cu_microc.md
# cu_microc

Run-controlled control unit for the `microc` single-cycle datapath. It decodes the 6-bit `Opcode` and the `z` flag into `s_inc`, `s_inm`, `we3`, `wez` and `Op`. It gates execution with a start/step/halt state machine and counts retired instructions. It sits beside `microc` in the CPU top and replaces the testbench-driven control signals. It adds `pc_en`; the `microc` PC register gains a matching write enable.

## Interface
- `CNT_W`, 16: width of the retired-instruction counter.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Opcode`  in  6  current instruction opcode from the datapath.
- `z`  in  1  zero flag from the datapath.
- `start`  in  1  pulse: begin or resume free-running execution.
- `step`  in  1  pulse: execute exactly one instruction.
- `halt_req`  in  1  request to stop after the current instruction.
- `s_inc`  out  1  1 = PC+1, 0 = load the jump address.
- `s_inm`  out  1  1 = write the immediate, 0 = write the ALU result.
- `we3`  out  1  register bank write enable.
- `wez`  out  1  z flag write enable.
- `Op`  out  3  ALU operation.
- `pc_en`  out  1  PC register write enable.
- `running`  out  1  high in RUN or STEP.
- `trap`  out  1  illegal opcode caught (sticky).
- `retired`  out  CNT_W  count of executed instructions.

## Operation
- Decode (valid when the state gate is open):
  - ALU: `Opcode[5]=1`. Op=`Opcode[4:2]`, s_inm=0, we3=1, wez=1, s_inc=1.
  - li: `Opcode[5:2]=0000`. s_inm=1, we3=1, wez=0, s_inc=1, Op=000.
  - j `000100`: s_inc=0, with no writes.
  - jz `001000`: s_inc=`~z`, with no writes.
  - jnz `001010`: s_inc=`z`, with no writes.
  - Any other opcode is illegal (see Configuration).
- State gate closed (IDLE, HALT): pc_en=we3=wez=0, s_inc=1, s_inm=0, Op=000.
- State gate open (RUN, STEP): pc_en=1 and the decoded values drive the outputs.
- FSM states: IDLE, RUN, STEP, HALT.
  - IDLE→RUN on `start`.
  - IDLE→STEP on `step` when `start` is low.
  - RUN→HALT on `halt_req`. The instruction in that cycle still executes.
  - STEP→IDLE unconditionally after its one cycle.
  - HALT→RUN on `start`. This clears `trap`.
  - HALT→STEP on `step`. This also clears `trap`.
- Input priority in every state: `halt_req` > `start` > `step`.
  - `halt_req` in IDLE moves the FSM to HALT.
  - `start` and `step` received in RUN are ignored.
- `retired` increments on every cycle with pc_en=1 and wraps from all-ones to 0.

## Timing
- Reset values:
  - state=IDLE, retired=0, trap=0, running=0, pc_en=0, we3=0, wez=0, s_inc=1, s_inm=0, Op=000.
- Control outputs are combinational from `Opcode`, `z` and the registered state, so decode latency is 0 cycles.
- The state, `trap` and `retired` are registered. A `start` pulse at edge N opens the gate in the cycle after N.
- The first instruction executes at edge N+1.
- `halt_req` asserted during cycle K: instruction K executes, and the gate is closed from cycle K+1.
- `z` is sampled in the same cycle as the jump. Reading a `wez` write from the preceding instruction is the datapath's responsibility.
- Reset asserted mid-operation forces IDLE immediately (asynchronously). No write enable remains high once reset is asserted.

## Configuration
- `CU_TRAP_EN` defined:
  - An illegal opcode in RUN or STEP closes the gate in that same cycle (no writes, pc_en=0).
  - It sets `trap` and moves the FSM to HALT. `retired` does not increment.
- `CU_TRAP_EN` undefined:
  - An illegal opcode executes as a NOP: pc_en=1, s_inc=1, no writes.
  - `retired` increments and `trap` is tied to 0.

## Structure
- Package `cu_pkg` holds:
  - opcode constants `OP_J`, `OP_JZ`, `OP_JNZ`, `OP_LI_PFX`;
  - ALU op constants `ALU_ADD=010`, `ALU_SUB=011`;
  - the FSM state typedef `cu_state_t`.
- One sub-module, `cu_decode`: purely combinational, mapping `Opcode`/`z` to the raw control fields and an `illegal` flag.
- The gating, FSM, trap and counter are in `cu_microc`.

## Test plan
- Reset, then start. The IDLE gate is closed until start; li `000010` with the gate open gives s_inm=1, we3=1, pc_en=1, and `retired` goes 0→1.
- Decode checks:
  - ALU `101000` gives Op=010, wez=1.
  - jnz with z=0 gives s_inc=0; with z=1 it gives s_inc=1.
  - jz with z=1 gives s_inc=0.
- Step from IDLE: exactly one cycle with pc_en=1, then IDLE, with `retired`=1. A second step gives `retired`=2.
- halt_req in RUN cycle K: K has we3=1, K+1 has pc_en=0 and state HALT. Start then resumes.
- With `CU_TRAP_EN`, opcode `001111` in RUN gives we3=0, pc_en=0, trap=1, state HALT and unchanged `retired`. Without the macro: pc_en=1 and `retired`+1.
- Set `retired`=0xFFFF by running 65535 instructions, then one more gives 0. Reset asserted mid-RUN immediately gives pc_en=0 and `retired`=0.
